// File: rtl/mem_buffer_sequencer_pkg.sv
// mem_buffer_sequencer_pkg
//   Shared types and default sizing for the memory buffer sequencer.
//   vaddress_t / alloc_size_t / buffer_t describe a buffer descriptor.
//   seq_state_t is the sequencer FSM encoding, exposed on the bus for debug.
//   XFER_LEN_BITS is the request length width for the default MAX_XFER.
package mem_buffer_sequencer_pkg;

  localparam int DEF_VADDR_BITS      = 48;
  localparam int DEF_SIZE_BITS       = 32;
  localparam int DEF_MAX_XFER        = 4096;
  localparam int DEF_MAX_OUTSTANDING = 8;

  // A request can be exactly MAX_XFER bytes long, hence the extra bit.
  localparam int XFER_LEN_BITS = $clog2(DEF_MAX_XFER) + 1;

  typedef logic [DEF_VADDR_BITS-1:0] vaddress_t;
  typedef logic [DEF_SIZE_BITS-1:0]  alloc_size_t;

  typedef struct packed {
    vaddress_t   vaddr;
    alloc_size_t size;
  } buffer_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mem_buffer_sequencer_if.sv
// mem_buffer_sequencer_if
//   Bundles the descriptor, request, completion and done channels.
//   master : the environment (descriptor source, memory engine, done sink).
//   slave  : the sequencer.
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high; a source holds valid and its payload stable until
//   that edge. cpl_valid is a one-cycle pulse with no ready.
//   state is a debug view of the sequencer FSM.
interface mem_buffer_sequencer_if
  import mem_buffer_sequencer_pkg::*;
#(
  parameter int VADDR_BITS = DEF_VADDR_BITS,
  parameter int SIZE_BITS  = DEF_SIZE_BITS,
  parameter int LEN_BITS   = XFER_LEN_BITS
);

  logic                  buf_valid;
  logic                  buf_ready;
  logic [VADDR_BITS-1:0] buf_vaddr;
  logic [SIZE_BITS-1:0]  buf_size;

  logic                  req_valid;
  logic                  req_ready;
  logic [VADDR_BITS-1:0] req_vaddr;
  logic [LEN_BITS-1:0]   req_len;

  logic                  cpl_valid;

  logic                  done_valid;
  logic                  done_ready;

  seq_state_t            state;

  modport master (
    output buf_valid, buf_vaddr, buf_size,
    input  buf_ready,
    input  req_valid, req_vaddr, req_len,
    output req_ready,
    output cpl_valid,
    input  done_valid,
    output done_ready,
    input  state
  );

  modport slave (
    input  buf_valid, buf_vaddr, buf_size,
    output buf_ready,
    output req_valid, req_vaddr, req_len,
    input  req_ready,
    input  cpl_valid,
    output done_valid,
    input  done_ready,
    output state
  );

endinterface

// File: rtl/mem_seq_chunker.sv
// mem_seq_chunker
//   Combinational sizing of the next memory request.
//   addr    : current request address
//   rem     : bytes still to request
//   req_len : min(rem, bytes left before the next MAX_XFER boundary)
//   last    : this request finishes the buffer
module mem_seq_chunker #(
  parameter int VADDR_BITS = 48,
  parameter int SIZE_BITS  = 32,
  parameter int MAX_XFER   = 4096,
  parameter int LEN_BITS   = $clog2(MAX_XFER) + 1
) (
  input  logic [VADDR_BITS-1:0] addr,
  input  logic [SIZE_BITS-1:0]  rem,
  output logic [LEN_BITS-1:0]   req_len,
  output logic                  last
);

  logic [LEN_BITS-1:0] room;

  always_comb begin
    // MAX_XFER is a power of two, so the mask gives addr mod MAX_XFER.
    room    = LEN_BITS'(MAX_XFER) - LEN_BITS'(addr & VADDR_BITS'(MAX_XFER - 1));
    last    = (rem <= SIZE_BITS'(room));
    req_len = last ? LEN_BITS'(rem) : room;
  end

endmodule

// File: rtl/mem_buffer_sequencer.sv
// mem_buffer_sequencer
//   Accepts one buffer descriptor at a time, splits it into requests that
//   never cross a MAX_XFER boundary, limits issued-but-uncompleted requests
//   to MAX_OUTSTANDING and raises done once every request has completed.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     bus (slave)   : buf_*, req_*, cpl_valid, done_*, debug state
//     err_cpl       : sticky, completion seen while nothing was outstanding
//     stat_buffers  : completed buffers (wrapping)
//     stat_bytes    : completed bytes (wrapping)
//   Build option: define MEM_BUFFER_SEQUENCER_STATS_EN to enable the
//   statistics counters; otherwise both statistics outputs are tied to 0.
module mem_buffer_sequencer
  import mem_buffer_sequencer_pkg::*;
#(
  parameter int VADDR_BITS      = DEF_VADDR_BITS,
  parameter int SIZE_BITS       = DEF_SIZE_BITS,
  parameter int MAX_XFER        = DEF_MAX_XFER,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_buffer_sequencer_if.slave  bus,
  output logic                   err_cpl,
  output logic [31:0]            stat_buffers,
  output logic [63:0]            stat_bytes
);

  localparam int LEN_BITS = $clog2(MAX_XFER) + 1;
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_BITS-1:0] OUT_MAX = CNT_BITS'(MAX_OUTSTANDING);
  localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);

  seq_state_t            state;
  logic [VADDR_BITS-1:0] addr;
  logic [SIZE_BITS-1:0]  rem;
  logic [CNT_BITS-1:0]   outstanding;
  logic [CNT_BITS-1:0]   out_next;
  logic [LEN_BITS-1:0]   chunk_len;
  logic                  chunk_last;
  logic                  buf_fire;
  logic                  req_fire;
  logic                  done_fire;
  logic                  cpl_spurious;

  mem_seq_chunker #(
    .VADDR_BITS (VADDR_BITS),
    .SIZE_BITS  (SIZE_BITS),
    .MAX_XFER   (MAX_XFER),
    .LEN_BITS   (LEN_BITS)
  ) u_chunker (
    .addr    (addr),
    .rem     (rem),
    .req_len (chunk_len),
    .last    (chunk_last)
  );

  // Request payload comes straight from registers, so it cannot change
  // while a request is stalled.
  assign bus.req_vaddr = addr;
  assign bus.req_len   = chunk_len;
  assign bus.state     = state;

  assign buf_fire     = bus.buf_valid & bus.buf_ready;
  assign req_fire     = bus.req_valid & bus.req_ready;
  assign done_fire    = bus.done_valid & bus.done_ready;
  assign cpl_spurious = bus.cpl_valid & (outstanding == '0);

  // A coincident issue and completion cancel out; a completion with nothing
  // outstanding leaves the counter at zero.
  always_comb begin
    out_next = outstanding;
    if (req_fire && !bus.cpl_valid) begin
      out_next = outstanding + ONE;
    end else if (!req_fire && bus.cpl_valid && outstanding != '0) begin
      out_next = outstanding - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.buf_ready  <= 1'b0;
      bus.req_valid  <= 1'b0;
      bus.done_valid <= 1'b0;
      addr           <= '0;
      rem            <= '0;
      outstanding    <= '0;
      err_cpl        <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (cpl_spurious) begin
        err_cpl <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (buf_fire) begin
            addr          <= bus.buf_vaddr;
            rem           <= bus.buf_size;
            bus.buf_ready <= 1'b0;
            if (bus.buf_size == '0) begin
              state          <= DONE;
              bus.done_valid <= 1'b1;
            end else begin
              state         <= ISSUE;
              bus.req_valid <= (out_next < OUT_MAX);
            end
          end else begin
            bus.buf_ready <= 1'b1;
          end
        end

        ISSUE: begin
          if (req_fire) begin
            addr <= addr + VADDR_BITS'(chunk_len);
            rem  <= rem - SIZE_BITS'(chunk_len);
          end
          if (req_fire && chunk_last) begin
            state         <= DRAIN;
            bus.req_valid <= 1'b0;
          end else begin
            // Registered view of "room for another request next cycle".
            bus.req_valid <= (out_next < OUT_MAX);
          end
        end

        DRAIN: begin
          if (outstanding == '0) begin
            state          <= DONE;
            bus.done_valid <= 1'b1;
          end
        end

        DONE: begin
          if (done_fire) begin
            state          <= IDLE;
            bus.done_valid <= 1'b0;
            bus.buf_ready  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_BUFFER_SEQUENCER_STATS_EN
  logic [SIZE_BITS-1:0] size_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q       <= '0;
      stat_buffers <= '0;
      stat_bytes   <= '0;
    end else begin
      if (buf_fire) begin
        size_q <= bus.buf_size;
      end
      if (done_fire) begin
        stat_buffers <= stat_buffers + 32'd1;
        stat_bytes   <= stat_bytes + 64'(size_q);
      end
    end
  end
`else
  assign stat_buffers = '0;
  assign stat_bytes   = '0;
`endif

endmodule
